// File: rtl/urv_dm_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: read-owner encoding
// and default starvation limit.
package urv_dm_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CORE = 2'b01,
        OWN_DBG  = 2'b10
    } owner_e;

    localparam int unsigned DEF_STARVE_LIMIT = 8;
    localparam int unsigned DEF_CNT_W        = 8;

endpackage

// File: rtl/urv_dm_arbiter.sv
// Two-master arbiter for the data-memory port: core has priority, the
// debug/DMA master is guaranteed a slot after STARVE_LIMIT lost contests.
module urv_dm_arbiter
    import urv_dm_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        core_pend_i,
    input  logic        core_load_i,
    input  logic        core_store_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_data_i,
    input  logic [3:0]  core_sel_i,
    output logic        core_ready_o,
    output logic [31:0] core_rdata_o,

    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_data_i,
    input  logic [3:0]  dbg_sel_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_rvalid_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_sel_o,
    output logic        mem_load_o,
    output logic        mem_store_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    owner_e           rd_owner_q;
    logic             dbg_grant;

    // Grant looks only at core intent, not its strobes, so the core's stall
    // path never loops back through the arbiter.
    assign dbg_grant    = dbg_req_i && (!core_pend_i || starve_cnt == LIMIT);
    assign core_ready_o = mem_ready_i && !dbg_grant;
    assign dbg_ack_o    = dbg_grant && mem_ready_i;

    assign core_rdata_o = mem_rdata_i;
    assign dbg_rdata_o  = mem_rdata_i;
    assign dbg_rvalid_o = (rd_owner_q == OWN_DBG);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        mem_addr_o  = core_addr_i;
        mem_data_o  = core_data_i;
        mem_sel_o   = core_sel_i;
        mem_load_o  = core_load_i;
        mem_store_o = core_store_i;
        if (dbg_grant) begin
            mem_addr_o  = dbg_addr_i;
            mem_data_o  = dbg_data_i;
            mem_sel_o   = dbg_sel_i;
            mem_load_o  = dbg_req_i && !dbg_we_i;
            mem_store_o = dbg_req_i && dbg_we_i;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; reset here is synchronous to clk_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
            rd_owner_q <= OWN_NONE;
        end else begin
            if (!dbg_req_i || dbg_ack_o) begin
                starve_cnt <= '0;
            end else if (core_pend_i && !dbg_grant && mem_ready_i && starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (mem_load_o && mem_ready_i) begin
                rd_owner_q <= dbg_grant ? OWN_DBG : OWN_CORE;
            end else begin
                rd_owner_q <= OWN_NONE;
            end
        end
    end

    // The core must never strobe while it is being stalled.
    a_core_strobe_when_ready : assert property (
        @(posedge clk_i) disable iff (rst_i)
        !((core_load_i || core_store_i) && !core_ready_o)
    );

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Self-checking bench for urv_dm_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_urv_dm_arbiter;
    import urv_dm_arbiter_pkg::*;

    localparam int LIMIT = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_pend_i, core_load_i, core_store_i;
    logic [31:0] core_addr_i, core_data_i;
    logic [3:0]  core_sel_i;
    logic        core_ready_o;
    logic [31:0] core_rdata_o;
    logic        dbg_req_i, dbg_we_i;
    logic [31:0] dbg_addr_i, dbg_data_i;
    logic [3:0]  dbg_sel_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
    logic        dbg_rvalid_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [3:0]  mem_sel_o;
    logic        mem_load_o, mem_store_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;

    urv_dm_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_pend_i  (core_pend_i),
        .core_load_i  (core_load_i),
        .core_store_i (core_store_i),
        .core_addr_i  (core_addr_i),
        .core_data_i  (core_data_i),
        .core_sel_i   (core_sel_i),
        .core_ready_o (core_ready_o),
        .core_rdata_o (core_rdata_o),
        .dbg_req_i    (dbg_req_i),
        .dbg_we_i     (dbg_we_i),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_data_i   (dbg_data_i),
        .dbg_sel_i    (dbg_sel_i),
        .dbg_ack_o    (dbg_ack_o),
        .dbg_rdata_o  (dbg_rdata_o),
        .dbg_rvalid_o (dbg_rvalid_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_sel_o    (mem_sel_o),
        .mem_load_o   (mem_load_o),
        .mem_store_o  (mem_store_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        rst;
        logic        core_pend;
        logic        want_load;
        logic        want_store;
        logic [31:0] core_addr;
        logic [31:0] core_data;
        logic [3:0]  core_sel;
        logic        dbg_req;
        logic        dbg_we;
        logic [31:0] dbg_addr;
        logic [31:0] dbg_data;
        logic [3:0]  dbg_sel;
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } stim_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: lost contests in a row, and whether a dbg read returns next.
    int m_lost     = 0;
    bit m_dbg_ret  = 1'b0;
    bit m_last_ack = 1'b0;
    logic obs_ack, obs_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s           = '0;
        s.mem_ready = 1'b1;
        s.core_sel  = 4'hf;
        s.dbg_sel   = 4'hf;
        s.mem_rdata = $urandom;
        return s;
    endfunction

    task automatic cycle(input stim_t s);
        bit grant, ready, ld, st, exp_ld, exp_st;
        logic [31:0] exp_addr, exp_data;
        logic [3:0]  exp_sel;
        @(negedge clk_i);
        grant = s.dbg_req && (!s.core_pend || m_lost >= LIMIT);
        ready = s.mem_ready && !grant;
        ld    = s.core_pend && s.want_load && ready;
        st    = s.core_pend && s.want_store && !s.want_load && ready;

        rst_i        = s.rst;
        core_pend_i  = s.core_pend;
        core_load_i  = ld;
        core_store_i = st;
        core_addr_i  = s.core_addr;
        core_data_i  = s.core_data;
        core_sel_i   = s.core_sel;
        dbg_req_i    = s.dbg_req;
        dbg_we_i     = s.dbg_we;
        dbg_addr_i   = s.dbg_addr;
        dbg_data_i   = s.dbg_data;
        dbg_sel_i    = s.dbg_sel;
        mem_ready_i  = s.mem_ready;
        mem_rdata_i  = s.mem_rdata;
        #1;

        if (grant) begin
            exp_ld = s.dbg_req && !s.dbg_we;  exp_st = s.dbg_req && s.dbg_we;
            exp_addr = s.dbg_addr;  exp_data = s.dbg_data;  exp_sel = s.dbg_sel;
        end else begin
            exp_ld = ld;  exp_st = st;
            exp_addr = s.core_addr; exp_data = s.core_data; exp_sel = s.core_sel;
        end

        check("core_ready", 32'(core_ready_o), 32'(ready));
        check("dbg_ack",    32'(dbg_ack_o),    32'(grant && s.mem_ready));
        check("dbg_rvalid", 32'(dbg_rvalid_o), 32'(m_dbg_ret));
        check("mem_load",   32'(mem_load_o),   32'(exp_ld));
        check("mem_store",  32'(mem_store_o),  32'(exp_st));
        check("core_rdata", core_rdata_o, s.mem_rdata);
        if (m_dbg_ret) check("dbg_rdata", dbg_rdata_o, s.mem_rdata);
        if (exp_ld || exp_st) begin
            check("mem_addr", mem_addr_o, exp_addr);
            check("mem_sel",  32'(mem_sel_o), 32'(exp_sel));
        end
        if (exp_st) check("mem_data", mem_data_o, exp_data);
        obs_ack   = dbg_ack_o;
        obs_ready = core_ready_o;

        @(posedge clk_i);
        m_last_ack = grant && s.mem_ready;
        if (s.rst) begin
            m_lost    = 0;
            m_dbg_ret = 1'b0;
        end else begin
            m_dbg_ret = grant && s.mem_ready && s.dbg_req && !s.dbg_we;
            if (!s.dbg_req || m_last_ack) m_lost = 0;
            else if (s.mem_ready && m_lost < LIMIT) m_lost++;
        end
    endtask

    // Core and debug both pushing; returns the index of the first dbg acceptance.
    task automatic contend(input int n, input int stall_from, input int stall_len, output int first_ack);
        stim_t s;
        first_ack = -1;
        for (int i = 0; i < n; i++) begin
            s = idle();
            s.core_pend = 1'b1;  s.want_load = 1'b1;  s.core_addr = 32'h300 + 32'(i);
            s.dbg_req   = 1'b1;  s.dbg_addr  = 32'h4000;
            if (i >= stall_from && i < stall_from + stall_len) s.mem_ready = 1'b0;
            cycle(s);
            if (obs_ack && first_ack < 0) first_ack = i;
            if (first_ack >= 0 && i == first_ack + 1) check("resume_ready", 32'(obs_ready), 32'd1);
        end
    endtask

    initial begin
        stim_t s;
        int    ack_at;
        bit    d_req, d_we;
        logic [31:0] d_addr, d_data;
        logic [3:0]  d_sel;

        s = idle(); s.rst = 1'b1;
        cycle(s); cycle(s);
        s = idle(); cycle(s);

        // Core-only load, then its return cycle.
        s = idle(); s.core_pend = 1'b1; s.want_load = 1'b1; s.core_addr = 32'h100;
        cycle(s);
        check("core_load_addr", mem_addr_o, 32'h100);
        s = idle(); s.mem_rdata = 32'hCAFEF00D; cycle(s);

        // Debug-only load with data return.
        s = idle(); s.dbg_req = 1'b1; s.dbg_addr = 32'h2000;
        cycle(s);
        check("dbg_only_ack", 32'(obs_ack), 32'd1);
        s = idle(); s.mem_rdata = 32'hDEADBEEF; cycle(s);
        check("dbg_load_data", dbg_rdata_o, 32'hDEADBEEF);

        // Contention: forced slot on the ninth contested cycle.
        contend(12, 99, 0, ack_at);
        check("starve_slot", 32'(ack_at), 32'(LIMIT));
        s = idle(); cycle(s);

        // Backpressure mid-contention holds the count.
        contend(14, 3, 3, ack_at);
        check("starve_slot_bp", 32'(ack_at), 32'(LIMIT + 3));
        s = idle(); cycle(s);

        // Debug store.
        s = idle(); s.dbg_req = 1'b1; s.dbg_we = 1'b1; s.dbg_sel = 4'b0011;
        s.dbg_data = 32'h1234; s.dbg_addr = 32'h2004;
        cycle(s);
        check("dbg_store_sel", 32'(mem_sel_o), 32'h3);
        s = idle(); cycle(s);

        // Reset after a dbg load acceptance, and reset during one.
        s = idle(); s.dbg_req = 1'b1; s.dbg_addr = 32'h2008; cycle(s);
        s = idle(); s.rst = 1'b1; cycle(s);
        s = idle(); cycle(s);
        check("rvalid_after_rst", 32'(dbg_rvalid_o), 32'd0);
        s = idle(); s.rst = 1'b1; s.dbg_req = 1'b1; s.dbg_addr = 32'h200c; cycle(s);
        s = idle(); cycle(s);
        check("rvalid_dropped", 32'(dbg_rvalid_o), 32'd0);

        // Partial contention, reset, then the full limit is needed again.
        contend(4, 99, 0, ack_at);
        s = idle(); s.rst = 1'b1; s.core_pend = 1'b1; s.dbg_req = 1'b1; cycle(s);
        contend(10, 99, 0, ack_at);
        check("starve_after_rst", 32'(ack_at), 32'(LIMIT));
        s = idle(); cycle(s);

        // Randomized traffic; the debug master holds its request until accepted.
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_data = '0; d_sel = '0;
        m_last_ack = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (m_last_ack || !d_req) begin
                d_req  = ($urandom_range(0, 2) != 0);
                d_we   = $urandom_range(0, 1) == 1;
                d_addr = $urandom; d_data = $urandom; d_sel = 4'($urandom);
            end
            s            = idle();
            s.rst        = ($urandom_range(0, 199) == 0);
            s.core_pend  = ($urandom_range(0, 3) != 0);
            s.want_load  = $urandom_range(0, 1) == 1;
            s.want_store = $urandom_range(0, 1) == 1;
            s.core_addr  = $urandom; s.core_data = $urandom; s.core_sel = 4'($urandom);
            s.dbg_req    = d_req;  s.dbg_we = d_we;  s.dbg_addr = d_addr;
            s.dbg_data   = d_data; s.dbg_sel = d_sel;
            s.mem_ready  = ($urandom_range(0, 3) != 0);
            cycle(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
